// File: rtl/stage3_exec_unit_if.sv
// Stage-3 execute bus: issue-side operands and controls in, results and pipeline control out.
// master = upstream/testbench side, slave = execute unit.
interface stage3_exec_unit_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_BYPASS = 2,
    parameter int unsigned INSTR_W    = 5
);
    logic                       stall;
    logic                       valid;
    logic [INSTR_W-1:0]         instr_type;
    logic [3:0]                 branch_type;
    logic                       mul_req;
    logic [XLEN-1:0]            pc;
    logic [XLEN-1:0]            rs1_read;
    logic [XLEN-1:0]            rs2_read;
    logic [XLEN-1:0]            imm;
    logic [NUM_BYPASS-1:0]      rs1_byp_sel;
    logic [NUM_BYPASS-1:0]      rs2_byp_sel;
    logic [NUM_BYPASS*XLEN-1:0] byp_value;
    logic [XLEN-1:0]            eval;
    logic                       eval_valid;
    logic [XLEN-1:0]            link_addr;
    logic                       redirect_valid;
    logic [XLEN-1:0]            redirect_addr;
    logic                       do_flush;
    logic                       busy;

    modport master (
        output stall, valid, instr_type, branch_type, mul_req, pc, rs1_read, rs2_read, imm,
               rs1_byp_sel, rs2_byp_sel, byp_value,
        input  eval, eval_valid, link_addr, redirect_valid, redirect_addr, do_flush, busy
    );

    modport slave (
        input  stall, valid, instr_type, branch_type, mul_req, pc, rs1_read, rs2_read, imm,
               rs1_byp_sel, rs2_byp_sel, byp_value,
        output eval, eval_valid, link_addr, redirect_valid, redirect_addr, do_flush, busy
    );
endinterface

// File: rtl/stage3_exec_unit.sv
// Execute stage (stage 3): bypass operand select, ALU, branch/jal/jalr resolution with a
// registered redirect and a counted flush window.
// Optional iterative radix-2 multiplier enabled by defining STAGE3_MUL_EN.
// instr_type bits: [0] do_reg, [1] do_sub, [2] do_branch, [3] do_jal, [4] do_jalr.
// branch_type one-hot: [0] eq, [1] ne, [2] lt, [3] ge.
module stage3_exec_unit #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NUM_BYPASS   = 2,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic               clock,
    input logic               reset,
    stage3_exec_unit_if.slave bus
);
    localparam int unsigned DoReg    = 0;
    localparam int unsigned DoSub    = 1;
    localparam int unsigned DoBranch = 2;
    localparam int unsigned DoJal    = 3;
    localparam int unsigned DoJalr   = 4;
    localparam int unsigned MulCntW  = $clog2(XLEN + 1);

    typedef enum logic [1:0] {StIdle, StFlush, StMul} state_e;

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;

    logic [XLEN-1:0] arg1, arg2, rs2_val, alu, result, jalr_sum, target;
    logic [3:0]      cmp;
    logic            eq, lt, take, is_jump, kill, accept, mul_start, mul_done;
    logic [XLEN-1:0] mul_result;

    logic [XLEN-1:0] eval_q, link_q, redirect_addr_q;
    logic            eval_valid_q, redirect_valid_q;

`ifdef STAGE3_MUL_EN
    logic [XLEN-1:0]    mcand_q, mplier_q, acc_q, acc_step;
    logic [MulCntW-1:0] mul_cnt_q;
`else
    logic               unused_mul_req;
    assign unused_mul_req = bus.mul_req;
`endif

    // Operand select: lowest-index asserted bypass channel wins, else register file.
    always_comb begin
        arg1    = bus.rs1_read;
        rs2_val = bus.rs2_read;
        for (int k = int'(NUM_BYPASS) - 1; k >= 0; k--) begin
            if (bus.rs1_byp_sel[k]) arg1 = bus.byp_value[k*XLEN +: XLEN];
            if (bus.rs2_byp_sel[k]) rs2_val = bus.byp_value[k*XLEN +: XLEN];
        end
    end

    // ALU, compare and jump target.
    always_comb begin
        arg2     = (bus.instr_type[DoReg] | bus.instr_type[DoBranch]) ? rs2_val : bus.imm;
        alu      = bus.instr_type[DoSub] ? (arg1 - arg2) : (arg1 + arg2);
        eq       = (arg1 == arg2);
        lt       = ($signed(arg1) < $signed(arg2));
        cmp      = {~lt, lt, ~eq, eq};
        take     = |(bus.branch_type & cmp);
        result   = bus.instr_type[DoBranch] ? {{(XLEN-1){1'b0}}, take} : alu;
        jalr_sum = arg1 + bus.imm;
        target   = bus.instr_type[DoJalr] ? {jalr_sum[XLEN-1:1], 1'b0} : (bus.pc + bus.imm);
        is_jump  = bus.instr_type[DoJal] | bus.instr_type[DoJalr]
                 | (bus.instr_type[DoBranch] & take);
    end

    assign kill   = (state_q == StFlush);
    assign accept = bus.valid & ~bus.stall & ~kill & ~bus.busy;

`ifdef STAGE3_MUL_EN
    // A jump takes precedence over a multiply request in the same instruction.
    assign mul_start  = accept & bus.mul_req & ~is_jump;
    assign acc_step   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_result = acc_step;
`else
    assign mul_start  = 1'b0;
    assign mul_result = '0;
`endif

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: flush window countdown and multiplier completion; frozen under stall.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mul_done = 1'b0;
        if (!bus.stall) begin
            unique case (state_q)
                StIdle: begin
                    if (accept && is_jump) begin
                        state_d = StFlush;
                        cnt_d   = 3'(FLUSH_CYCLES);
                    end else if (mul_start) begin
                        state_d = StMul;
                    end
                end
                StFlush: begin
                    if (cnt_q <= 3'd1) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                StMul: begin
`ifdef STAGE3_MUL_EN
                    if (mul_cnt_q == MulCntW'(1)) begin
                        state_d  = StIdle;
                        mul_done = 1'b1;
                    end
`else
                    state_d = StIdle;
`endif
                end
                default: state_d = StIdle;
            endcase
        end
    end

`ifdef STAGE3_MUL_EN
    // Shift-add multiplier: one multiplier bit per non-stalled cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            mul_cnt_q <= '0;
        end else if (!bus.stall) begin
            if (mul_start) begin
                mcand_q   <= arg1;
                mplier_q  <= arg2;
                acc_q     <= '0;
                mul_cnt_q <= MulCntW'(XLEN);
            end else if (state_q == StMul) begin
                acc_q     <= acc_step;
                mcand_q   <= mcand_q << 1;
                mplier_q  <= mplier_q >> 1;
                mul_cnt_q <= mul_cnt_q - MulCntW'(1);
            end
        end
    end
`endif

    // Result, link and redirect registers; all held under stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            eval_q           <= '0;
            eval_valid_q     <= 1'b0;
            link_q           <= '0;
            redirect_valid_q <= 1'b0;
            redirect_addr_q  <= '0;
        end else if (!bus.stall) begin
            redirect_valid_q <= accept & is_jump;
            if (accept && is_jump) redirect_addr_q <= target;
            if (accept) link_q <= bus.pc + XLEN'(4);
            if (mul_done) begin
                eval_q       <= mul_result;
                eval_valid_q <= 1'b1;
            end else if (accept && !mul_start) begin
                eval_q       <= result;
                eval_valid_q <= 1'b1;
            end else begin
                eval_valid_q <= 1'b0;
            end
        end
    end

    assign bus.eval           = eval_q;
    assign bus.eval_valid     = eval_valid_q;
    assign bus.link_addr      = link_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_addr  = redirect_addr_q;
    assign bus.do_flush       = (state_q == StFlush);
`ifdef STAGE3_MUL_EN
    assign bus.busy           = (state_q == StMul);
`else
    assign bus.busy           = 1'b0;
`endif
endmodule

// File: tb/tb_stage3_exec_unit.sv
// Directed self-checking bench for stage3_exec_unit (XLEN=32, NUM_BYPASS=2, FLUSH_CYCLES=2).
module tb_stage3_exec_unit;
    localparam logic [4:0] OpAddi   = 5'b00000;
    localparam logic [4:0] OpAdd    = 5'b00001;
    localparam logic [4:0] OpSub    = 5'b00011;
    localparam logic [4:0] OpBranch = 5'b00100;
    localparam logic [4:0] OpJal    = 5'b01000;
    localparam logic [4:0] OpJalr   = 5'b10000;
    localparam logic [3:0] BrEq     = 4'b0001;
    localparam logic [3:0] BrLt     = 4'b0100;
    localparam logic [3:0] BrGe     = 4'b1000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    stage3_exec_unit_if #(.XLEN(32), .NUM_BYPASS(2), .INSTR_W(5)) bus ();

    stage3_exec_unit #(.XLEN(32), .NUM_BYPASS(2), .FLUSH_CYCLES(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall       = 1'b0;
        bus.valid       = 1'b0;
        bus.instr_type  = OpAddi;
        bus.branch_type = 4'b0000;
        bus.mul_req     = 1'b0;
        bus.pc          = '0;
        bus.rs1_read    = '0;
        bus.rs2_read    = '0;
        bus.imm         = '0;
        bus.rs1_byp_sel = '0;
        bus.rs2_byp_sel = '0;
        bus.byp_value   = {32'd7, 32'd5};
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if ({bus.eval, bus.link_addr, bus.redirect_addr} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h/%h want 0", bus.eval, bus.link_addr,
                     bus.redirect_addr);
        end
        n_checks++;
        if ({bus.eval_valid, bus.redirect_valid, bus.do_flush, bus.busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b%b%b%b want 0000", bus.eval_valid,
                     bus.redirect_valid, bus.do_flush, bus.busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_bypass();
        bus.valid = 1'b1; bus.instr_type = OpAddi; bus.rs1_read = 32'd9; bus.imm = 32'd1;
        bus.rs1_byp_sel = 2'b11;
        step();
        n_checks++;
        if (bus.eval !== 32'd6 || bus.eval_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL byp_both: got eval=%0d ev=%b want 6/1", bus.eval, bus.eval_valid);
        end
        bus.rs1_byp_sel = 2'b10;
        step();
        n_checks++;
        if (bus.eval !== 32'd8) begin
            n_fail++;
            $display("FAIL byp_ch1: got %0d want 8", bus.eval);
        end
        bus.rs1_byp_sel = 2'b00;
        step();
        n_checks++;
        if (bus.eval !== 32'd10) begin
            n_fail++;
            $display("FAIL byp_none: got %0d want 10", bus.eval);
        end
        bus.instr_type = OpSub; bus.rs1_read = 32'd20; bus.rs2_byp_sel = 2'b10;
        step();
        n_checks++;
        if (bus.eval !== 32'd13) begin
            n_fail++;
            $display("FAIL sub_rs2_byp: got %0d want 13", bus.eval);
        end
        idle_inputs();
        step();
        n_checks++;
        if (bus.eval_valid !== 1'b0 || bus.eval !== 32'd13) begin
            n_fail++;
            $display("FAIL idle_valid: got ev=%b eval=%0d want 0/13", bus.eval_valid, bus.eval);
        end
    endtask

    task automatic test_branch_flush();
        bus.valid = 1'b1; bus.instr_type = OpBranch; bus.branch_type = BrEq;
        bus.pc = 32'h100; bus.rs1_read = 32'd3; bus.rs2_read = 32'd3; bus.imm = 32'h20;
        step();
        n_checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_addr !== 32'h120) begin
            n_fail++;
            $display("FAIL beq_redirect: got %b/%h want 1/120", bus.redirect_valid,
                     bus.redirect_addr);
        end
        n_checks++;
        if (bus.do_flush !== 1'b1 || bus.eval !== 32'd1 || bus.link_addr !== 32'h104) begin
            n_fail++;
            $display("FAIL beq_state: got fl=%b eval=%h link=%h want 1/1/104", bus.do_flush,
                     bus.eval, bus.link_addr);
        end
        bus.instr_type = OpAdd; bus.branch_type = 4'b0000;
        bus.rs1_read = 32'd1; bus.rs2_read = 32'd1;
        step();
        n_checks++;
        if (bus.redirect_valid !== 1'b0 || bus.do_flush !== 1'b1 || bus.eval_valid !== 1'b0
            || bus.eval !== 32'd1) begin
            n_fail++;
            $display("FAIL flush_kill1: got rv=%b fl=%b ev=%b eval=%0d want 0/1/0/1",
                     bus.redirect_valid, bus.do_flush, bus.eval_valid, bus.eval);
        end
        step();
        n_checks++;
        if (bus.do_flush !== 1'b0 || bus.eval_valid !== 1'b0 || bus.eval !== 32'd1) begin
            n_fail++;
            $display("FAIL flush_kill2: got fl=%b ev=%b eval=%0d want 0/0/1", bus.do_flush,
                     bus.eval_valid, bus.eval);
        end
        step();
        n_checks++;
        if (bus.eval !== 32'd2 || bus.eval_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL post_flush_add: got %0d/%b want 2/1", bus.eval, bus.eval_valid);
        end
        idle_inputs();
    endtask

    task automatic test_jalr();
        bus.valid = 1'b1; bus.instr_type = OpJalr; bus.pc = 32'h40;
        bus.rs1_read = 32'h1001; bus.imm = 32'd2;
        step();
        n_checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_addr !== 32'h1002
            || bus.link_addr !== 32'h44) begin
            n_fail++;
            $display("FAIL jalr: got rv=%b addr=%h link=%h want 1/1002/44", bus.redirect_valid,
                     bus.redirect_addr, bus.link_addr);
        end
        idle_inputs();
        step();
        step();
        n_checks++;
        if (bus.do_flush !== 1'b0 || bus.redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL jalr_end: got fl=%b rv=%b want 0/0", bus.do_flush, bus.redirect_valid);
        end
    endtask

    task automatic test_signed_branch();
        bus.valid = 1'b1; bus.instr_type = OpBranch; bus.branch_type = BrLt;
        bus.pc = 32'h200; bus.rs1_read = 32'hFFFF_FFFF; bus.rs2_read = 32'd1; bus.imm = 32'h10;
        step();
        n_checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_addr !== 32'h210) begin
            n_fail++;
            $display("FAIL blt_taken: got %b/%h want 1/210", bus.redirect_valid,
                     bus.redirect_addr);
        end
        bus.valid = 1'b0;
        step();
        step();
        bus.valid = 1'b1; bus.branch_type = BrGe;
        step();
        n_checks++;
        if (bus.redirect_valid !== 1'b0 || bus.eval !== 32'd0 || bus.eval_valid !== 1'b1
            || bus.do_flush !== 1'b0) begin
            n_fail++;
            $display("FAIL bge_not_taken: got rv=%b eval=%0d ev=%b fl=%b want 0/0/1/0",
                     bus.redirect_valid, bus.eval, bus.eval_valid, bus.do_flush);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_stall_flush();
        int n_flush;
        bus.valid = 1'b1; bus.instr_type = OpBranch; bus.branch_type = BrEq; bus.imm = 32'h8;
        step();
        idle_inputs();
        bus.stall = 1'b1;
        n_flush = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.do_flush === 1'b1) n_flush++;
            n_checks++;
            if (bus.redirect_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold_rv: got %b want 1 (stall cycle %0d)",
                         bus.redirect_valid, i);
            end
            step();
        end
        bus.stall = 1'b0;
        for (int i = 0; i < 20 && bus.do_flush === 1'b1; i++) begin
            n_flush++;
            step();
        end
        n_checks++;
        if (n_flush != 5) begin
            n_fail++;
            $display("FAIL stall_flush_len: got %0d cycles want 5", n_flush);
        end
        bus.valid = 1'b1; bus.instr_type = OpJal; bus.pc = 32'h300; bus.imm = 32'h40;
        step();
        n_checks++;
        if (bus.redirect_addr !== 32'h340 || bus.do_flush !== 1'b1) begin
            n_fail++;
            $display("FAIL jal: got %h/%b want 340/1", bus.redirect_addr, bus.do_flush);
        end
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({bus.eval, bus.link_addr, bus.redirect_addr} !== 96'd0
            || {bus.eval_valid, bus.redirect_valid, bus.do_flush, bus.busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_flush: got %h/%h/%h %b%b%b%b want all 0", bus.eval,
                     bus.link_addr, bus.redirect_addr, bus.eval_valid, bus.redirect_valid,
                     bus.do_flush, bus.busy);
        end
    endtask

`ifdef STAGE3_MUL_EN
    task automatic test_mul();
        int n_busy;
        bus.valid = 1'b1; bus.instr_type = OpAdd; bus.mul_req = 1'b1;
        bus.rs1_read = 32'hFFFF_FFFF; bus.rs2_read = 32'd3;
        step();
        idle_inputs();
        n_busy = 0;
        for (int i = 0; i < 100 && bus.busy === 1'b1; i++) begin
            n_busy++;
            step();
        end
        n_checks++;
        if (n_busy != 32) begin
            n_fail++;
            $display("FAIL mul_busy_len: got %0d want 32", n_busy);
        end
        n_checks++;
        if (bus.eval !== 32'hFFFF_FFFD || bus.eval_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_result: got %h/%b want fffffffd/1", bus.eval, bus.eval_valid);
        end
        bus.valid = 1'b1; bus.instr_type = OpAdd; bus.mul_req = 1'b1;
        bus.rs1_read = 32'd6; bus.rs2_read = 32'd7;
        step();
        idle_inputs();
        for (int i = 0; i < 9; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.eval_valid !== 1'b0 || bus.eval !== 32'd0) begin
            n_fail++;
            $display("FAIL mul_reset: got busy=%b ev=%b eval=%h want 0/0/0", bus.busy,
                     bus.eval_valid, bus.eval);
        end
    endtask
`else
    task automatic test_mul();
        bus.valid = 1'b1; bus.instr_type = OpAdd; bus.mul_req = 1'b1;
        bus.rs1_read = 32'd5; bus.rs2_read = 32'd3;
        step();
        idle_inputs();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.eval !== 32'd8 || bus.eval_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_ignored: got busy=%b eval=%0d ev=%b want 0/8/1", bus.busy,
                     bus.eval, bus.eval_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bypass();
        test_branch_flush();
        test_jalr();
        test_signed_branch();
        test_stall_flush();
        test_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
